// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl - successive-approximation ADC sequencer.
//
// Drives a PWM DAC (enable / period / duty) and reads an external analog
// comparator. Each trial bit is written to the DAC, held for SETTLE_CYCLES so
// the RC filter settles, then judged against the synchronised comparator.
// The result is built MSB-first.
//
// Optional build macro: SAR_ADC_AVG_EN
//   When defined, four back-to-back conversions are summed and the truncated
//   mean is reported with a single done pulse.
//
// Ports:
//   clk, reset_n    system clock, asynchronous active-low reset
//   start           conversion request, only looked at in IDLE
//   cont            1 = restart automatically after each result
//   comp_in         asynchronous comparator, 1 = Vin > Vdac
//   dac_enable      PWM DAC enable (0 only while in reset)
//   dac_count       PWM period, constant all-ones
//   dac_duty        PWM duty for the current trial
//   busy            high while a conversion is in progress (SET/SETTLE/SAMPLE)
//   done            one-cycle pulse when result updates
//   result          last completed conversion
module sar_adc_ctrl #(
    parameter int WIDTH         = 12,
    parameter int SETTLE_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             cont,
    input  logic             comp_in,
    output logic             dac_enable,
    output logic [WIDTH-1:0] dac_count,
    output logic [WIDTH-1:0] dac_duty,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(SETTLE_CYCLES);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SET, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] trial;
    logic [IW-1:0]    bit_idx;
    logic [CW-1:0]    settle_cnt;
    logic             comp_m, comp_s;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] trial_fin;

`ifdef SAR_ADC_AVG_EN
    logic [1:0]       conv_cnt;
    logic [WIDTH+1:0] acc;
    logic [WIDTH+1:0] acc_sum;
    logic             fin;      // set when the DONE being entered reports
`endif

    assign dac_count = '1;
    assign bit_mask  = WIDTH'(1) << bit_idx;
    // Trial word after judging the current bit; also what result captures,
    // so result and done both appear on the edge that enters DONE.
    assign trial_fin = comp_s ? trial : (trial & ~bit_mask);

`ifdef SAR_ADC_AVG_EN
    assign acc_sum = acc + {2'b00, trial_fin};
`endif

    // Two-flop synchroniser for the asynchronous comparator.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            comp_m <= 1'b0;
            comp_s <= 1'b0;
        end else begin
            comp_m <= comp_in;
            comp_s <= comp_m;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SET;
            S_SET:    state_nxt = S_SETTLE;
            S_SETTLE: if (settle_cnt == CW'(SETTLE_CYCLES - 1)) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = (bit_idx == '0) ? S_DONE : S_SET;
            S_DONE: begin
`ifdef SAR_ADC_AVG_EN
                // Intermediate conversions of an average always continue.
                if (!fin)      state_nxt = S_SET;
                else
`endif
                if (cont)      state_nxt = S_SET;
                else           state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state == S_SET) || (state == S_SETTLE) || (state == S_SAMPLE);
`ifdef SAR_ADC_AVG_EN
        done = (state == S_DONE) && fin;
`else
        done = (state == S_DONE);
`endif
    end

    // Datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dac_enable <= 1'b0;
            dac_duty   <= '0;
            result     <= '0;
            trial      <= '0;
            bit_idx    <= '0;
            settle_cnt <= '0;
`ifdef SAR_ADC_AVG_EN
            conv_cnt   <= '0;
            acc        <= '0;
            fin        <= 1'b0;
`endif
        end else begin
            dac_enable <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        trial   <= '0;
                        bit_idx <= IW'(WIDTH - 1);
                    end
                end
                S_SET: begin
                    dac_duty   <= trial | bit_mask;
                    trial      <= trial | bit_mask;
                    settle_cnt <= '0;
                end
                S_SETTLE: settle_cnt <= settle_cnt + 1'b1;
                S_SAMPLE: begin
                    trial <= trial_fin;
                    if (bit_idx == '0) begin
`ifdef SAR_ADC_AVG_EN
                        if (conv_cnt == 2'd3) begin
                            result   <= acc_sum[WIDTH+1:2];
                            acc      <= '0;
                            conv_cnt <= '0;
                            fin      <= 1'b1;
                        end else begin
                            acc      <= acc_sum;
                            conv_cnt <= conv_cnt + 2'd1;
                            fin      <= 1'b0;
                        end
`else
                        result <= trial_fin;
`endif
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                    end
                end
                S_DONE: begin
                    trial   <= '0;
                    bit_idx <= IW'(WIDTH - 1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl with WIDTH=4, SETTLE_CYCLES=2.
// The comparator is modelled as comp_in = (dac_duty <= vin), or forced low.
module tb_sar_adc_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       cont;
    logic       comp_in;
    logic       dac_enable;
    logic [3:0] dac_count;
    logic [3:0] dac_duty;
    logic       busy;
    logic       done;
    logic [3:0] result;

    logic [3:0] vin;
    logic       tie0;
    int         n_assert = 0;
    int         n_fail   = 0;
    int         n_done;

    sar_adc_ctrl #(.WIDTH(4), .SETTLE_CYCLES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .cont       (cont),
        .comp_in    (comp_in),
        .dac_enable (dac_enable),
        .dac_count  (dac_count),
        .dac_duty   (dac_duty),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    assign comp_in = tie0 ? 1'b0 : (dac_duty <= vin);

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One single-shot conversion; edge 0 is the edge that samples start.
    task automatic conv(input string tag, input logic [3:0] v, input logic t0,
                        input logic [3:0] d3, input logic [3:0] d2,
                        input logic [3:0] d1, input logic [3:0] d0,
                        input logic [3:0] r);
        vin = v; tie0 = t0;
        start = 1'b1; tick(1); start = 1'b0;
        chk({tag, " busy e0"}, busy, 1);
        tick(1);  chk({tag, " duty e1"}, dac_duty, d3);
        tick(4);  chk({tag, " duty e5"}, dac_duty, d2);
        tick(4);  chk({tag, " duty e9"}, dac_duty, d1);
        tick(4);  chk({tag, " duty e13"}, dac_duty, d0);
        tick(2);  chk({tag, " done e15"}, done, 0);
        tick(1);  chk({tag, " done e16"}, done, 1);
                  chk({tag, " result e16"}, result, r);
                  chk({tag, " busy e16"}, busy, 0);
        tick(1);  chk({tag, " done e17"}, done, 0);
                  chk({tag, " busy e17"}, busy, 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; cont = 1'b0; vin = 4'd0; tie0 = 1'b0;
        #12;
        chk("rst duty", dac_duty, 0);
        chk("rst result", result, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst enable", dac_enable, 0);
        chk("rst count", dac_count, 4'hF);
        reset_n = 1'b1;
        tick(1);
        chk("enable after rst", dac_enable, 1);
        chk("idle busy", busy, 0);
        tick(3);
        chk("idle no start", busy, 0);

`ifdef SAR_ADC_AVG_EN
        // Four averaged conversions with VIN 8,10,8,10 -> one done, mean 9.
        vin = 4'd8;
        start = 1'b1; tick(1); start = 1'b0;
        tick(16); chk("avg no done e16", done, 0);  vin = 4'd10;
        tick(17); chk("avg no done e33", done, 0);  vin = 4'd8;
        tick(17); chk("avg no done e50", done, 0);  vin = 4'd10;
        tick(16); chk("avg no done e66", done, 0);
        tick(1);  chk("avg done e67", done, 1);
                  chk("avg result", result, 9);
        tick(1);  chk("avg done e68", done, 0);
                  chk("avg idle", busy, 0);
`else
        // Scenario 1/2: basic conversions
        conv("vin9",  4'd9,  1'b0, 4'd8, 4'd12, 4'd10, 4'd9,  4'd9);
        conv("vin15", 4'd15, 1'b0, 4'd8, 4'd12, 4'd14, 4'd15, 4'd15);
        tick(3);
        conv("tie0",  4'd15, 1'b1, 4'd8, 4'd4,  4'd2,  4'd1,  4'd0);
        tie0 = 1'b0;
        tick(3);

        // Scenario 3: start re-pulsed while busy is ignored
        vin = 4'd9; n_done = 0;
        start = 1'b1; tick(1); start = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            start = (e == 3) || (e == 10);
            tick(1);
            if (done) n_done++;
        end
        start = 1'b0;
        chk("restart done count", n_done, 1);
        chk("restart result", result, 9);
        chk("restart idle", busy, 0);

        // Scenario 4: reset mid-conversion
        vin = 4'd9;
        start = 1'b1; tick(1); start = 1'b0;
        tick(6);
        chk("abort busy e6", busy, 1);
        chk("abort duty e6", dac_duty, 12);
        reset_n = 1'b0;
        #1;
        chk("abort duty", dac_duty, 0);
        chk("abort busy", busy, 0);
        chk("abort result", result, 0);
        chk("abort enable", dac_enable, 0);
        chk("abort done", done, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        conv("post abort", 4'd9, 1'b0, 4'd8, 4'd12, 4'd10, 4'd9, 4'd9);
        tick(2);

        // Scenario 5: continuous mode, 17 cycles between results
        cont = 1'b1; vin = 4'd5;
        start = 1'b1; tick(1); start = 1'b0;
        tick(16); chk("cont done e16", done, 1);
                  chk("cont result 5", result, 5);
        vin = 4'd11;
        tick(1);  chk("cont busy e17", busy, 1);
        tick(15); chk("cont done e32", done, 0);
        tick(1);  chk("cont done e33", done, 1);
                  chk("cont result 11", result, 11);
        tick(7);  cont = 1'b0;
        tick(10); chk("cont done e50", done, 1);
                  chk("cont result e50", result, 11);
        n_done = 0;
        for (int e = 51; e <= 70; e++) begin
            tick(1);
            if (done) n_done++;
        end
        chk("cont stop dones", n_done, 0);
        chk("cont stop idle", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Successive-approximation controller that sequences the PWM DAC plus an external analog comparator to form a WIDTH-bit ADC.
- Drives the DAC duty cycle, period and enable.
- Waits a programmable settling time per trial bit.
- Samples the synchronised comparator and builds the result MSB-first.
- Sits between the PWM DAC, the comparator input pin and the display/readout logic.

Parameters:
WIDTH, 12, DAC/ADC resolution in bits; must match the PWM DAC width.
SETTLE_CYCLES, 4096, clk cycles held per trial bit for RC filter settling; legal range is 2 or more.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  conversion request; sampled only in IDLE
cont  input  1  continuous mode; 1 = restart automatically after each result
comp_in  input  1  asynchronous comparator output; 1 = Vin > Vdac
dac_enable  output  1  PWM DAC enable
dac_count  output  WIDTH  PWM period value, constant all-ones
dac_duty  output  WIDTH  PWM duty cycle for the current trial
busy  output  1  high in SET, SETTLE, SAMPLE
done  output  1  one-cycle pulse when result updates
result  output  WIDTH  last completed conversion; held until the next done

Behaviour:
- Reset (async, reset_n=0) forces: state IDLE; dac_duty=0; result=0; busy=0; done=0; dac_enable=0; synchroniser and all counters cleared.
- After reset: dac_enable=1 constantly; dac_count = all-ones at all times.
- Comparator path: comp_in passes through a 2-flop synchroniser giving comp_s. The SAMPLE state uses only comp_s.
- Registers: trial (WIDTH), bit_idx, settle_cnt (clog2(SETTLE_CYCLES) bits).
- FSM states: IDLE, SET, SETTLE, SAMPLE, DONE.
  - IDLE: if start=1 -> SET, with trial=0 and bit_idx=WIDTH-1. Otherwise stay; dac_duty holds its last value.
  - SET: dac_duty <= trial | (1<<bit_idx); trial <= the same value; settle_cnt <= 0; -> SETTLE.
  - SETTLE: settle_cnt increments; when settle_cnt==SETTLE_CYCLES-1 -> SAMPLE. Exactly SETTLE_CYCLES cycles are spent here.
  - SAMPLE: if comp_s=0, clear trial[bit_idx]. If bit_idx==0 -> DONE; else decrement bit_idx -> SET.
  - DONE: result <= trial; done=1 for this cycle only. If cont=1 -> SET with trial=0, bit_idx=WIDTH-1; else -> IDLE.
- Latency: each bit takes SETTLE_CYCLES+2 cycles.
  - done is high in the cycle after edge WIDTH*(SETTLE_CYCLES+2), counted from the edge that sampled start (edge 0).
  - result changes on that same edge.
  - In continuous mode, results repeat every WIDTH*(SETTLE_CYCLES+2)+1 cycles.
- Boundary conditions:
  - start while busy or in DONE: ignored, not queued.
  - cont deasserted mid-conversion: the current conversion completes, then the FSM returns to IDLE.
  - reset_n low mid-conversion: immediate abort to reset values; result is not updated.
  - comp_in changing during SETTLE: has no effect until SAMPLE.
  - SETTLE_CYCLES must be 2 or more, so comp_s has seen the new dac_duty by SAMPLE.

Optional Feature:
Macro SAR_ADC_AVG_EN.
- Defined:
  - A 2-bit conversion counter and a (WIDTH+2)-bit accumulator are added.
  - In DONE: acc += trial.
  - If conv_cnt!=3: conv_cnt++, no done pulse, -> SET with trial=0.
  - If conv_cnt==3: result <= (acc+trial)>>2 (truncating), done=1, acc=0, conv_cnt=0.
  - done occurs 4*WIDTH*(SETTLE_CYCLES+2)+3 edges after start.
  - Reset and abort clear acc and conv_cnt.
- Undefined: single-conversion behaviour as above; no accumulator logic is present.

Test Plan:
Common setup for all scenarios:
- WIDTH=4, SETTLE_CYCLES=2.
- Comparator model: comp_in = (dac_duty <= VIN).

Scenarios:
1. VIN=9, pulse start -> dac_duty sequence 8,12,10,9; done at edge 16 after start; result=9; busy low in DONE.
2. VIN=15 -> duty 8,12,14,15, result=15. comp_in tied 0 -> duty 8,4,2,1, result=0. Both at the 16-cycle latency.
3. VIN=9, start, then start re-pulsed at edges 3 and 10 -> exactly one done; result=9; FSM returns to IDLE.
4. reset_n low at edge 7 of a VIN=9 conversion -> immediately dac_duty=0, busy=0, result=0, dac_enable=0; after release, a fresh start gives result 9.
5. cont=1, VIN=5, then VIN=11 after the first done -> done pulses 17 cycles apart; results 5 then 11; clearing cont stops after the current conversion.
6. (SAR_ADC_AVG_EN) VIN changed per conversion to 8,10,8,10 -> single done at edge 67; result=9.
